// File: rtl/iodelay_pkg.sv
// Shared types and helpers for the IDELAY tap sequencer.
package iodelay_pkg;

  localparam int unsigned TAP_W_DEF = 6;

  typedef enum logic [2:0] {IDLE, RST, LATCH, INC, DONE} state_e;

  // Index width for n items, at least 1 bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v != 0) begin
      r++;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/iodelay_tap_sequencer_if.sv
// Config-side request bus and IDELAY-side strobe bus of the tap sequencer.
interface iodelay_tap_sequencer_if import iodelay_pkg::*; #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned TAP_W = TAP_W_DEF
);
  localparam int unsigned AW = clog2(NCH);

  logic [NCH-1:0]       req;
  logic [NCH*TAP_W-1:0] spec_delay;
  logic [NCH-1:0]       idly_rst;
  logic [NCH-1:0]       idly_ce;
  logic                 busy;
  logic                 done;
  logic [AW-1:0]        active_ch;
  logic [NCH*TAP_W-1:0] actual_delay;

  modport master (
    output req, spec_delay,
    input  idly_rst, idly_ce, busy, done, active_ch, actual_delay
  );

  modport slave (
    input  req, spec_delay,
    output idly_rst, idly_ce, busy, done, active_ch, actual_delay
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick of the first pending channel after last_i, wrapping at NCH.
module rr_arbiter import iodelay_pkg::*; #(
  parameter int unsigned NCH = 4
) (
  input  logic [NCH-1:0]        pending_i,
  input  logic [clog2(NCH)-1:0] last_i,
  output logic [NCH-1:0]        gnt_oh_o,
  output logic [clog2(NCH)-1:0] gnt_idx_o
);
  localparam int unsigned AW = clog2(NCH);

  logic [AW-1:0] cand;
  logic          found;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = last_i;
    for (int unsigned k = 0; k < NCH; k++) begin
      cand = (cand == AW'(NCH - 1)) ? '0 : cand + AW'(1);
      if (!found && pending_i[cand]) begin
        found           = 1'b1;
        gnt_oh_o[cand]  = 1'b1;
        gnt_idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/iodelay_tap_sequencer.sv
// Serialises per-channel IDELAY reloads: reset the element, then CE-strobe it up to the
// requested tap, tracking the taps driven into every channel.
module iodelay_tap_sequencer import iodelay_pkg::*; #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned TAP_W   = TAP_W_DEF,
  parameter int unsigned RST_CYC = 2
) (
  input  logic                   clk40,
  input  logic                   rst_n,
  iodelay_tap_sequencer_if.slave bus
);
  localparam int unsigned AW  = clog2(NCH);
  localparam int unsigned RCW = 4;

  state_e                    state_q, state_d;
  logic [NCH-1:0]            pend_q, pend_d;
  logic [AW-1:0]             last_q, last_d;
  logic [AW-1:0]             ach_q, ach_d;
  logic [RCW-1:0]            rcnt_q, rcnt_d;
  logic [TAP_W-1:0]          cnt_q, cnt_d;
  logic [TAP_W-1:0]          tgt_q, tgt_d;
  logic [NCH-1:0][TAP_W-1:0] act_q, act_d;
  logic [NCH-1:0]            rst_q, rst_d;
  logic [NCH-1:0]            ce_q, ce_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic [NCH-1:0]            gnt_oh;
  logic [AW-1:0]             gnt_idx;
  logic [NCH-1:0]            sel_oh;
  logic [NCH-1:0][TAP_W-1:0] spec_arr;
  logic [TAP_W-1:0]          spec_sel;

  assign spec_arr = bus.spec_delay;
  assign spec_sel = spec_arr[ach_q];

  rr_arbiter #(.NCH(NCH)) u_arb (
    .pending_i (pend_q),
    .last_i    (last_q),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx)
  );

  // Next state; strobes are decoded from the next state so they line up with it.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q | bus.req;
    last_d  = last_q;
    ach_d   = ach_q;
    rcnt_d  = rcnt_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    act_d   = act_q;
    sel_oh  = NCH'(1) << ach_q;
    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          ach_d          = gnt_idx;
          sel_oh         = gnt_oh;
          act_d[gnt_idx] = '0;
          rcnt_d         = '0;
          state_d        = RST;
        end
      end
      RST: begin
        rcnt_d = rcnt_q + RCW'(1);
        if (rcnt_q == RCW'(RST_CYC - 1)) state_d = LATCH;
      end
      LATCH: begin
        tgt_d   = spec_sel;
        cnt_d   = '0;
        state_d = (spec_sel == '0) ? DONE : INC;
      end
      INC: begin
        cnt_d        = cnt_q + TAP_W'(1);
        act_d[ach_q] = act_q[ach_q] + TAP_W'(1);
        if (cnt_d == tgt_q) state_d = DONE;
      end
      DONE: begin
        // A request arriving in the done cycle re-queues the channel.
        pend_d  = (pend_q & ~sel_oh) | bus.req;
        last_d  = ach_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rst_d  = (state_d == RST) ? sel_oh : '0;
    ce_d   = (state_d == INC) ? sel_oh : '0;
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk40) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      last_q  <= AW'(NCH - 1);
      ach_q   <= '0;
      rcnt_q  <= '0;
      cnt_q   <= '0;
      tgt_q   <= '0;
      act_q   <= '0;
      rst_q   <= '0;
      ce_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      ach_q   <= ach_d;
      rcnt_q  <= rcnt_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      act_q   <= act_d;
      rst_q   <= rst_d;
      ce_q    <= ce_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.idly_rst     = rst_q;
  assign bus.idly_ce      = ce_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.active_ch    = ach_q;
  assign bus.actual_delay = act_q;

endmodule

// File: tb/tb_iodelay_tap_sequencer.sv
// Bench for iodelay_tap_sequencer: timed reload model feeding a completion scoreboard.
module tb_iodelay_tap_sequencer;
  import iodelay_pkg::*;

  localparam int NCH     = 4;
  localparam int TAP_W   = 6;
  localparam int RST_CYC = 2;

  logic clk40 = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk40 = ~clk40;

  logic [NCH-1:0]            req_v;
  logic [NCH-1:0][TAP_W-1:0] spec_v;

  iodelay_tap_sequencer_if #(.NCH(NCH), .TAP_W(TAP_W)) bus ();
  assign bus.req        = req_v;
  assign bus.spec_delay = spec_v;

  iodelay_tap_sequencer #(.NCH(NCH), .TAP_W(TAP_W), .RST_CYC(RST_CYC)) dut (
    .clk40 (clk40),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {int ch; int tgt; int done_cyc;} exp_t;
  exp_t sb[$];
  int   served_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NCH-1:0] p, input int last);
    for (int k = 1; k <= NCH; k++)
      if (p[(last + k) % NCH]) return (last + k) % NCH;
    return 0;
  endfunction

  // Reload timeline from grant edge g: rst g..g+R-1, latch g+R, CE for tgt cycles, done.
  int             cyc = 0;
  logic [NCH-1:0] m_pend;
  int             m_last, m_ch, m_g, m_tgt, m_done, m_free;
  bit             m_busy, m_has_tgt;
  logic [NCH-1:0] x_rst, x_ce;
  bit             x_busy, x_done;
  int             x_act;

  initial begin
    m_pend = '0; m_last = NCH - 1; m_busy = 0; m_has_tgt = 0; m_free = 0;
    m_ch = 0; m_g = 0; m_tgt = 0; m_done = 0;
    x_rst = '0; x_ce = '0; x_busy = 0; x_done = 0; x_act = 0;
    forever begin
      @(posedge clk40);
      cyc++;
      if (!rst_n) begin
        if (m_busy && m_has_tgt && cyc <= m_done) void'(sb.pop_back());
        m_pend = '0; m_last = NCH - 1; m_busy = 0; m_has_tgt = 0; m_free = cyc + 1; x_act = 0;
      end else begin
        if (!m_busy && cyc >= m_free && m_pend != '0) begin
          m_ch = rr_pick(m_pend, m_last); m_busy = 1; m_has_tgt = 0; m_g = cyc; x_act = m_ch;
        end
        if (m_busy && !m_has_tgt && cyc == m_g + RST_CYC + 1) begin
          m_tgt = int'(spec_v[m_ch]); m_has_tgt = 1; m_done = m_g + RST_CYC + m_tgt + 1;
          sb.push_back('{m_ch, m_tgt, m_done});
        end
        if (m_busy && m_has_tgt && cyc == m_done + 1) begin
          m_pend[m_ch] = 1'b0; m_last = m_ch; m_busy = 0; m_has_tgt = 0; m_free = cyc + 1;
        end
        m_pend |= req_v;
      end
      x_rst = '0; x_ce = '0;
      x_busy = m_busy;
      x_done = m_busy && m_has_tgt && cyc == m_done;
      if (m_busy && cyc < m_g + RST_CYC) x_rst[m_ch] = 1'b1;
      if (m_busy && m_has_tgt && cyc < m_done) x_ce[m_ch] = 1'b1;
    end
  end

  // Monitor: per-cycle strobe checks plus scoreboard pop on every done pulse.
  initial begin
    int ce_cnt[NCH];
    int rst_run;
    logic [NCH-1:0] prev_rst;
    exp_t e;
    rst_run = 0; prev_rst = '0;
    foreach (ce_cnt[i]) ce_cnt[i] = 0;
    forever begin
      @(negedge clk40);
      check("strobes", {bus.idly_rst, bus.idly_ce}, {x_rst, x_ce});
      check("busy_done", {bus.busy, bus.done}, {x_busy, x_done});
      check("active_ch", bus.active_ch, x_act);
      check("one_strobe", ($countones({bus.idly_rst, bus.idly_ce}) <= 1), 1);
      if (bus.idly_rst != '0 && prev_rst == '0) rst_run = 0;
      if (bus.idly_rst != '0) rst_run++;
      for (int i = 0; i < NCH; i++) begin
        if (bus.idly_rst[i]) ce_cnt[i] = 0;
        else if (bus.idly_ce[i]) ce_cnt[i]++;
      end
      prev_rst = bus.idly_rst;
      if (bus.done) begin
        served_q.push_back(int'(bus.active_ch));
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          check("done_ch", bus.active_ch, e.ch);
          check("done_cycle", cyc, e.done_cyc);
          check("done_actual", bus.actual_delay[e.ch*TAP_W +: TAP_W], e.tgt);
          check("done_ce_count", ce_cnt[e.ch], e.tgt);
          check("done_rst_len", rst_run, RST_CYC);
        end
      end
    end
  end

  task automatic pulse(input logic [NCH-1:0] m);
    req_v = m;
    @(negedge clk40);
    req_v = '0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk40);
      if (!m_busy && m_pend == '0) return;
    end
    check("wait_idle_timeout", 1, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk40);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    req_v = '0; spec_v = '0;
    repeat (3) @(negedge clk40);
    check("reset_strobes", {bus.idly_rst, bus.idly_ce, bus.busy, bus.done, bus.active_ch}, 0);
    check("reset_actual", bus.actual_delay, 0);
    rst_n = 1'b1;

    // Single request, spec 5.
    spec_v[2] = 6'd5;
    pulse(4'b0100);
    wait_idle(100);
    check("t1_actual2", bus.actual_delay[2*TAP_W +: TAP_W], 5);
    check("t1_busy_after", bus.busy, 0);

    // Zero and maximum tap.
    spec_v[1] = 6'd0;
    pulse(4'b0010);
    wait_idle(100);
    spec_v[3] = 6'd63;
    pulse(4'b1000);
    wait_idle(200);
    check("t2_actual1", bus.actual_delay[1*TAP_W +: TAP_W], 0);
    check("t2_actual3", bus.actual_delay[3*TAP_W +: TAP_W], 63);

    // All channels at once after reset: served 0,1,2,3.
    do_reset();
    for (int i = 0; i < NCH; i++) spec_v[i] = TAP_W'(i + 1);
    served_q.delete();
    pulse(4'b1111);
    wait_idle(200);
    check("t3_count", served_q.size(), NCH);
    for (int i = 0; i < NCH && i < served_q.size(); i++) check("t3_order", served_q[i], i);

    // Fairness: ch0 held, ch3 pulsed once during ch0's first reload.
    for (int i = 0; i < NCH; i++) spec_v[i] = 6'd2;
    served_q.delete();
    req_v = 4'b0001;
    repeat (3) @(negedge clk40);
    req_v = 4'b1001;
    @(negedge clk40);
    req_v = 4'b0001;
    repeat (25) @(negedge clk40);
    req_v = '0;
    wait_idle(100);
    check("t4_first", (served_q.size() > 0) ? served_q[0] : -1, 0);
    check("t4_second", (served_q.size() > 1) ? served_q[1] : -1, 3);

    // Spec change mid-INC; re-request on the active channel held through its done cycle.
    spec_v[1] = 6'd5;
    served_q.delete();
    pulse(4'b0010);
    n = 0;
    while (n < 60 && !bus.idly_ce[1]) begin @(negedge clk40); n++; end
    check("t5_ce_seen", bus.idly_ce[1], 1);
    spec_v[1] = 6'd10;
    req_v = 4'b0010;
    n = 0;
    while (n < 60 && !bus.done) begin @(negedge clk40); n++; end
    check("t5_done_seen", bus.done, 1);
    @(negedge clk40);
    req_v = '0;
    wait_idle(100);
    check("t5_reloads", served_q.size(), 2);
    check("t5_actual1", bus.actual_delay[1*TAP_W +: TAP_W], 10);

    // Reset after 3 CE strobes of a long reload.
    spec_v[2] = 6'd20;
    pulse(4'b0100);
    n = 0;
    for (int i = 0; i < 60 && n < 3; i++) begin
      if (bus.idly_ce[2]) n++;
      if (n < 3) @(negedge clk40);
    end
    check("t6_three_ce", n, 3);
    rst_n = 1'b0;
    @(negedge clk40);
    check("t6_rst_strobes", {bus.idly_rst, bus.idly_ce, bus.busy, bus.done, bus.active_ch}, 0);
    check("t6_rst_actual", bus.actual_delay, 0);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk40);
      check("t6_quiet", {bus.idly_ce, bus.busy}, 0);
    end

    // Randomised requests and spec changes.
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < NCH; i++) req_v[i] = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) spec_v[$urandom_range(0, NCH - 1)] = TAP_W'($urandom_range(0, 15));
      @(negedge clk40);
    end
    req_v = '0;
    wait_idle(600);
    check("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
